quant_zigzag_collect: RTL and testbench
=======================================

Name: quant_zigzag_collect

Overview:
- Downstream consumer of the per-coefficient quantizer stage.
- Collects 16 quantized levels and their per-coefficient errors for one 4x4 block. Levels arrive in raster order, one per cycle.
- Reorders levels into VP8 zigzag order, clamps them to the legal level range, and derives the last-nonzero zigzag index and the error sum.
- Presents each complete block to the token/residual stage over a valid/ready handshake. Ping-pong buffering sustains 1 coefficient/cycle.

Parameters:
MAX_LEVEL, 2047, magnitude limit for output levels (symmetric clamp to +/-MAX_LEVEL).
LVL_W, 16, signed width of incoming and stored levels.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_level/in_err valid this cycle
in_ready  out  1  block can accept a coefficient
in_level  in  LVL_W  signed quantized level, raster position = internal count
in_err  in  8  signed quantization error for same coefficient
out_valid  out  1  complete block available
out_ready  in  1  consumer accepts block
out_levels  out  16*LVL_W  zigzag-ordered levels, slot n at bits [n*LVL_W +: LVL_W]
out_last  out  5  signed index of last nonzero zigzag slot, -1 (5'h1F) if none
out_nz  out  1  block has at least one nonzero level
out_err_sum  out  12  signed sum of the 16 in_err values
out_clip  out  1  at least one level was clamped
nz_count  out  5  number of nonzero levels (only with QZC_STATS_EN)

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All buffers, metadata, counters and pointers clear to 0. out_valid=0, in_ready=1, all outputs 0.
- Storage: two buffers (A/B). Each holds 16 levels plus last, nz, err_sum, clip, and nz_count. Control state: wr_sel, rd_sel, full[1:0], 4-bit raster counter cnt, running accumulators.
- Input acceptance:
  - in_ready = !full[wr_sel].
  - Accept when in_valid && in_ready. Non-accepted cycles change nothing.
- On accept:
  - Clamp: if in_level > MAX_LEVEL, store MAX_LEVEL; if in_level < -MAX_LEVEL, store -MAX_LEVEL; otherwise store unchanged. Clamping sets the clip accumulator.
  - Write the level into buf[wr_sel] slot inv_zz[cnt]. inv_zz maps raster 0..15 to zigzag slot 0,1,5,6,2,4,7,12,3,8,11,13,9,10,14,15.
  - If the stored level != 0: last_acc = max(last_acc, inv_zz[cnt]). last_acc starts at -1.
  - err_acc += sign-extended in_err (12-bit, cannot overflow).
  - cnt++.
- On accept with cnt==15:
  - The final coefficient's updates are folded into the buffer metadata in the same cycle.
  - Set full[wr_sel]=1, toggle wr_sel.
  - Reset cnt, last_acc (-1), err_acc, clip and count accumulators.
- Output:
  - out_valid = full[rd_sel]. All out_* are a mux of buffer registers selected by rd_sel and stay stable while out_valid && !out_ready.
  - On out_valid && out_ready: clear full[rd_sel], toggle rd_sel.
- Latency: out_valid rises the cycle after the 16th accept when that buffer is rd_sel. Sustained throughput is 16 cycles/block with out_ready held high.
- Simultaneous events: completion into one buffer and drain of the other in the same cycle are both honoured.
- Both buffers full: in_ready=0 until the next drain. in_ready returns 1 the cycle after the handshake.
- Partial block: cnt holds across stall cycles. There is no timeout or flush.
- Reset mid-block: the partial block is discarded. The next accept is raster 0.

Optional Feature:
QZC_STATS_EN
- Defined: per-block nonzero-level counter (0..16 needs 5 bits; 16 saturates to 5'd16) stored with the buffer and driven on nz_count.
- Undefined: counter logic and the nz_count port are absent.

Test Plan:
1. Raster levels r+1 (r=0..15), in_err=0, out_ready=1 -> slot0=1, slot2=5, slot3=9, slot7=7, slot15=16; out_last=15, out_nz=1, out_err_sum=0, out_valid the cycle after the 16th accept.
2. All levels 0, in_err=-3 each -> out_last=5'h1F, out_nz=0, out_err_sum=-48 (12'hFD0), out_clip=0.
3. Only raster 7 = -4 -> slot12=-4, all other slots 0, out_last=12, nz_count=1 (with QZC_STATS_EN).
4. Raster0=3000, raster1=-2500, rest 0 -> slot0=2047, slot1=-2047, out_clip=1, out_last=1.
5. out_ready=0, three blocks streamed back-to-back -> in_ready falls after the 32nd accept. Pulse out_ready -> block1 then block2 emerge in order, third block completes with no data loss.
6. Assert rst_n low after 9 accepts -> out_valid=0, in_ready=1. The next 16 accepts form one block starting at raster 0.

Source files
------------

// File: rtl/quant_zigzag_collect.sv
// rtl/quant_zigzag_collect.sv - collects 16 quantized levels per 4x4 block, zigzag-reorders them and emits ping-pong buffered blocks
// Optional feature macro: QZC_STATS_EN adds a per-block nonzero counter on nz_count.
module quant_zigzag_collect #(
    parameter int MAX_LEVEL = 2047,
    parameter int LVL_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LVL_W-1:0]     in_level,
    input  logic [7:0]           in_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*LVL_W-1:0]  out_levels,
    output logic [4:0]           out_last,
    output logic                 out_nz,
    output logic [11:0]          out_err_sum,
    output logic                 out_clip
`ifdef QZC_STATS_EN
    ,
    output logic [4:0]           nz_count
`endif
);

    localparam logic signed [LVL_W-1:0] P_MAX = LVL_W'(MAX_LEVEL);
    localparam logic signed [LVL_W-1:0] P_MIN = -P_MAX;

    // raster position -> zigzag slot
    function automatic logic [3:0] f_inv_zz(input logic [3:0] r);
        logic [3:0] s;
        case (r)
            4'd0:    s = 4'd0;
            4'd1:    s = 4'd1;
            4'd2:    s = 4'd5;
            4'd3:    s = 4'd6;
            4'd4:    s = 4'd2;
            4'd5:    s = 4'd4;
            4'd6:    s = 4'd7;
            4'd7:    s = 4'd12;
            4'd8:    s = 4'd3;
            4'd9:    s = 4'd8;
            4'd10:   s = 4'd11;
            4'd11:   s = 4'd13;
            4'd12:   s = 4'd9;
            4'd13:   s = 4'd10;
            4'd14:   s = 4'd14;
            default: s = 4'd15;
        endcase
        return s;
    endfunction

    // Per-buffer storage
    logic [LVL_W-1:0] r_lv [0:1][0:15];
    logic [4:0]       r_last  [0:1];
    logic             r_nz    [0:1];
    logic [11:0]      r_err   [0:1];
    logic             r_clip  [0:1];

    // Control state and running accumulators
    logic        r_wr_sel;
    logic        r_rd_sel;
    logic [1:0]  r_full;
    logic [3:0]  r_cnt;
    logic [3:0]  r_last_acc;
    logic        r_nz_acc;
    logic [11:0] r_err_acc;
    logic        r_clip_acc;

    logic                    w_accept;
    logic                    w_drain;
    logic                    w_done;
    logic signed [LVL_W-1:0] w_in_s;
    logic [LVL_W-1:0]        w_lvl;
    logic                    w_clamped;
    logic [3:0]              w_slot;
    logic                    w_is_nz;
    logic [3:0]              w_last_nx;
    logic                    w_nz_nx;
    logic [11:0]             w_err_nx;
    logic                    w_clip_nx;
    logic [4:0]              w_last_fin;
    logic [1:0]              w_full_nx;

    assign in_ready  = !r_full[r_wr_sel];
    assign out_valid = r_full[r_rd_sel];
    assign w_accept  = in_valid && in_ready;
    assign w_drain   = out_valid && out_ready;
    assign w_done    = w_accept && (r_cnt == 4'd15);

    assign w_in_s = signed'(in_level);

    always_comb begin
        w_lvl     = in_level;
        w_clamped = 1'b0;
        if (w_in_s > P_MAX) begin
            w_lvl     = P_MAX;
            w_clamped = 1'b1;
        end else if (w_in_s < P_MIN) begin
            w_lvl     = P_MIN;
            w_clamped = 1'b1;
        end
    end

    assign w_slot  = f_inv_zz(r_cnt);
    assign w_is_nz = (w_lvl != '0);

    // r_nz_acc doubles as the "last_acc is -1" marker so last_acc can reset to 0
    always_comb begin
        w_last_nx = r_last_acc;
        if (w_is_nz && (!r_nz_acc || (w_slot > r_last_acc)))
            w_last_nx = w_slot;
    end

    assign w_nz_nx    = r_nz_acc | w_is_nz;
    assign w_err_nx   = r_err_acc + {{4{in_err[7]}}, in_err};
    assign w_clip_nx  = r_clip_acc | w_clamped;
    assign w_last_fin = w_nz_nx ? {1'b0, w_last_nx} : 5'h1F;

    // Completion and drain always target different buffers, so both bits can move at once
    always_comb begin
        w_full_nx = r_full;
        if (w_drain)
            w_full_nx[r_rd_sel] = 1'b0;
        if (w_done)
            w_full_nx[r_wr_sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 16; j++)
                    r_lv[i][j] <= '0;
                r_last[i] <= '0;
                r_nz[i]   <= 1'b0;
                r_err[i]  <= '0;
                r_clip[i] <= 1'b0;
            end
            r_wr_sel   <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_full     <= '0;
            r_cnt      <= '0;
            r_last_acc <= '0;
            r_nz_acc   <= 1'b0;
            r_err_acc  <= '0;
            r_clip_acc <= 1'b0;
        end else begin
            r_full <= w_full_nx;
            if (w_drain)
                r_rd_sel <= !r_rd_sel;
            if (w_accept) begin
                r_lv[r_wr_sel][w_slot] <= w_lvl;
                if (w_done) begin
                    r_last[r_wr_sel] <= w_last_fin;
                    r_nz[r_wr_sel]   <= w_nz_nx;
                    r_err[r_wr_sel]  <= w_err_nx;
                    r_clip[r_wr_sel] <= w_clip_nx;
                    r_wr_sel         <= !r_wr_sel;
                    r_cnt            <= '0;
                    r_last_acc       <= '0;
                    r_nz_acc         <= 1'b0;
                    r_err_acc        <= '0;
                    r_clip_acc       <= 1'b0;
                end else begin
                    r_cnt      <= r_cnt + 4'd1;
                    r_last_acc <= w_last_nx;
                    r_nz_acc   <= w_nz_nx;
                    r_err_acc  <= w_err_nx;
                    r_clip_acc <= w_clip_nx;
                end
            end
        end
    end

`ifdef QZC_STATS_EN
    logic [4:0] r_nzc     [0:1];
    logic [4:0] r_nzc_acc;
    logic [4:0] w_nzc_nx;

    assign w_nzc_nx = (r_nzc_acc == 5'd16) ? 5'd16 : (r_nzc_acc + {4'd0, w_is_nz});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nzc[0]  <= '0;
            r_nzc[1]  <= '0;
            r_nzc_acc <= '0;
        end else if (w_accept) begin
            if (w_done) begin
                r_nzc[r_wr_sel] <= w_nzc_nx;
                r_nzc_acc       <= '0;
            end else begin
                r_nzc_acc <= w_nzc_nx;
            end
        end
    end

    assign nz_count = r_nzc[r_rd_sel];
`endif

    always_comb begin
        out_levels = '0;
        for (int i = 0; i < 16; i++)
            out_levels[i*LVL_W +: LVL_W] = r_lv[r_rd_sel][i];
    end

    assign out_last    = r_last[r_rd_sel];
    assign out_nz      = r_nz[r_rd_sel];
    assign out_err_sum = r_err[r_rd_sel];
    assign out_clip    = r_clip[r_rd_sel];

endmodule

// File: tb/tb_quant_zigzag_collect.sv
// tb/tb_quant_zigzag_collect.sv - directed self-checking bench for quant_zigzag_collect
module tb_quant_zigzag_collect;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_level;
    logic [7:0]   in_err;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_levels;
    logic [4:0]   out_last;
    logic         out_nz;
    logic [11:0]  out_err_sum;
    logic         out_clip;
`ifdef QZC_STATS_EN
    logic [4:0]   nz_count;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    // zigzag slot -> raster position
    localparam int ZZ [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

    quant_zigzag_collect #(.MAX_LEVEL(2047), .LVL_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_level    (in_level),
        .in_err      (in_err),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_levels  (out_levels),
        .out_last    (out_last),
        .out_nz      (out_nz),
        .out_err_sum (out_err_sum),
        .out_clip    (out_clip)
`ifdef QZC_STATS_EN
        ,
        .nz_count    (nz_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    // Block whose raster r carries base+r, viewed in zigzag order
    function automatic logic [255:0] exp_blk(input int base);
        logic [255:0] v;
        v = '0;
        for (int s = 0; s < 16; s++)
            v[s*16 +: 16] = 16'(base + ZZ[s]);
        return v;
    endfunction

    // Entered and left at a falling edge; waits (bounded) for in_ready
    task automatic push(input logic [15:0] lv, input logic [7:0] er);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_level = lv;
        in_err   = er;
        while (!in_ready && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fails++;
            $display("FAIL push_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, t);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_out_ready();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
        n_checks++;
        if (out_levels !== 256'd0) begin n_fails++; $display("FAIL reset_out_levels: got %h required 0", out_levels); end
        n_checks++;
        if ({out_last, out_nz, out_err_sum, out_clip} !== 19'd0) begin
            n_fails++;
            $display("FAIL reset_meta: got last=%h nz=%0b err=%h clip=%0b required all 0", out_last, out_nz, out_err_sum, out_clip);
        end
    endtask

    task automatic test_raster_ramp();
        out_ready = 1'b1;
        for (int r = 0; r < 15; r++)
            push(16'(r + 1), 8'd0);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fails++; $display("FAIL ramp_early_valid: got %0b required 0", out_valid); end
        push(16'd16, 8'd0);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fails++; $display("FAIL ramp_latency: out_valid got %0b required 1", out_valid); end
        n_checks++;
        if (out_levels !== exp_blk(1)) begin n_fails++; $display("FAIL ramp_levels: got %h required %h", out_levels, exp_blk(1)); end
        n_checks++;
        if (out_levels[2*16 +: 16] !== 16'd5 || out_levels[7*16 +: 16] !== 16'd7) begin
            n_fails++;
            $display("FAIL ramp_slot2_7: got %0d,%0d required 5,7", out_levels[2*16 +: 16], out_levels[7*16 +: 16]);
        end
        n_checks++;
        if (out_last !== 5'd15 || out_nz !== 1'b1 || out_err_sum !== 12'd0 || out_clip !== 1'b0) begin
            n_fails++;
            $display("FAIL ramp_meta: got last=%0d nz=%0b err=%h clip=%0b required 15,1,000,0", out_last, out_nz, out_err_sum, out_clip);
        end
`ifdef QZC_STATS_EN
        n_checks++;
        if (nz_count !== 5'd16) begin n_fails++; $display("FAIL ramp_nz_count: got %0d required 16", nz_count); end
`endif
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fails++; $display("FAIL ramp_drain: out_valid got %0b required 0", out_valid); end
    endtask

    task automatic test_all_zero();
        for (int r = 0; r < 16; r++)
            push(16'd0, 8'hFD);
        n_checks++;
        if (out_valid !== 1'b1 || out_levels !== 256'd0) begin
            n_fails++;
            $display("FAIL zero_block: valid=%0b levels=%h required 1 and 0", out_valid, out_levels);
        end
        n_checks++;
        if (out_last !== 5'h1F || out_nz !== 1'b0 || out_err_sum !== 12'hFD0 || out_clip !== 1'b0) begin
            n_fails++;
            $display("FAIL zero_meta: got last=%h nz=%0b err=%h clip=%0b required 1f,0,fd0,0", out_last, out_nz, out_err_sum, out_clip);
        end
`ifdef QZC_STATS_EN
        n_checks++;
        if (nz_count !== 5'd0) begin n_fails++; $display("FAIL zero_nz_count: got %0d required 0", nz_count); end
`endif
        @(negedge clk);
    endtask

    task automatic test_single_nonzero();
        logic [255:0] ev;
        ev = '0;
        ev[12*16 +: 16] = 16'hFFFC;
        for (int r = 0; r < 16; r++)
            push((r == 7) ? 16'hFFFC : 16'd0, 8'(r - 8));
        n_checks++;
        if (out_levels !== ev) begin n_fails++; $display("FAIL single_levels: got %h required %h", out_levels, ev); end
        n_checks++;
        if (out_last !== 5'd12 || out_nz !== 1'b1 || out_err_sum !== 12'hFF8) begin
            n_fails++;
            $display("FAIL single_meta: got last=%0d nz=%0b err=%h required 12,1,ff8", out_last, out_nz, out_err_sum);
        end
`ifdef QZC_STATS_EN
        n_checks++;
        if (nz_count !== 5'd1) begin n_fails++; $display("FAIL single_nz_count: got %0d required 1", nz_count); end
`endif
        @(negedge clk);
    endtask

    task automatic test_clamp();
        for (int r = 0; r < 16; r++)
            push((r == 0) ? 16'd3000 : (r == 1) ? 16'hF63C : 16'd0, 8'd0);
        n_checks++;
        if (out_levels[15:0] !== 16'h07FF || out_levels[31:16] !== 16'hF801 || out_levels[255:32] !== 224'd0) begin
            n_fails++;
            $display("FAIL clamp_levels: got %h required slot0=07ff slot1=f801 rest 0", out_levels);
        end
        n_checks++;
        if (out_clip !== 1'b1 || out_last !== 5'd1) begin
            n_fails++;
            $display("FAIL clamp_meta: got clip=%0b last=%0d required 1,1", out_clip, out_last);
        end
        @(negedge clk);
        // exact limits pass unclamped; err extremes sum to -1
        for (int r = 0; r < 16; r++)
            push((r == 2) ? 16'd2047 : (r == 3) ? 16'hF801 : 16'd0,
                 (r == 0) ? 8'h7F : (r == 1) ? 8'h80 : 8'd0);
        n_checks++;
        if (out_levels[5*16 +: 16] !== 16'd2047 || out_levels[6*16 +: 16] !== 16'hF801) begin
            n_fails++;
            $display("FAIL limit_levels: got slot5=%h slot6=%h required 07ff,f801", out_levels[5*16 +: 16], out_levels[6*16 +: 16]);
        end
        n_checks++;
        if (out_clip !== 1'b0 || out_last !== 5'd6 || out_err_sum !== 12'hFFF) begin
            n_fails++;
            $display("FAIL limit_meta: got clip=%0b last=%0d err=%h required 0,6,fff", out_clip, out_last, out_err_sum);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < 16; r++) begin
                push(16'(600 + b * 100 + r), 8'd1);
                n_checks++;
                if (in_ready !== 1'b1) begin n_fails++; $display("FAIL b2b_in_ready: block %0d raster %0d got %0b required 1", b, r, in_ready); end
            end
            n_checks++;
            if (out_valid !== 1'b1 || out_levels !== exp_blk(600 + b * 100) || out_err_sum !== 12'd16) begin
                n_fails++;
                $display("FAIL b2b_block%0d: valid=%0b levels=%h err=%h", b, out_valid, out_levels, out_err_sum);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int b = 1; b <= 2; b++)
            for (int r = 0; r < 16; r++)
                push(16'(b * 100 + r), 8'(b));
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL bp_full: in_ready=%0b out_valid=%0b required 0,1", in_ready, out_valid);
        end
        n_checks++;
        if (out_levels !== exp_blk(100) || out_err_sum !== 12'd16) begin
            n_fails++;
            $display("FAIL bp_block1: got %h err=%h required %h err=010", out_levels, out_err_sum, exp_blk(100));
        end
        // held coefficient must not be taken while both buffers are full
        in_valid = 1'b1;
        in_level = 16'd300;
        in_err   = 8'd3;
        repeat (3) @(negedge clk);
        pulse_out_ready();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_levels !== exp_blk(200) || out_err_sum !== 12'd32) begin
            n_fails++;
            $display("FAIL bp_block2: in_ready=%0b valid=%0b levels=%h err=%h", in_ready, out_valid, out_levels, out_err_sum);
        end
        for (int r = 0; r < 16; r++)
            push(16'(300 + r), 8'd3);
        n_checks++;
        if (in_ready !== 1'b0 || out_levels !== exp_blk(200)) begin
            n_fails++;
            $display("FAIL bp_hold: in_ready=%0b levels=%h required 0 and block2", in_ready, out_levels);
        end
        pulse_out_ready();
        n_checks++;
        if (out_valid !== 1'b1 || out_levels !== exp_blk(300) || out_err_sum !== 12'd48 || out_last !== 5'd15) begin
            n_fails++;
            $display("FAIL bp_block3: valid=%0b levels=%h err=%h last=%0d", out_valid, out_levels, out_err_sum, out_last);
        end
        pulse_out_ready();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL bp_empty: valid=%0b in_ready=%0b required 0,1", out_valid, in_ready);
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        for (int r = 0; r < 9; r++)
            push(16'(900 + r), 8'd5);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_levels !== 256'd0) begin
            n_fails++;
            $display("FAIL mid_reset: valid=%0b in_ready=%0b levels=%h required 0,1,0", out_valid, in_ready, out_levels);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 7; r++)
            push(16'(500 + r), 8'd2);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fails++; $display("FAIL mid_reset_stale: out_valid got %0b required 0", out_valid); end
        for (int r = 7; r < 16; r++)
            push(16'(500 + r), 8'd2);
        n_checks++;
        if (out_valid !== 1'b1 || out_levels !== exp_blk(500) || out_err_sum !== 12'd32) begin
            n_fails++;
            $display("FAIL mid_reset_block: valid=%0b levels=%h err=%h required 1,%h,020", out_valid, out_levels, out_err_sum, exp_blk(500));
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_level  = '0;
        in_err    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_raster_ramp();
        test_all_zero();
        test_single_nonzero();
        test_clamp();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
